// File: rtl/swhw_msg_pkg.sv
// Message-type encoding and lane indices shared by the outbound TX path.
package swhw_msg_pkg;

  typedef enum logic [7:0] {
    SWHW_MSG_TYPE_NONE                 = 8'h00,
    SWHW_MSG_TYPE_SESSION_REGISTRATION = 8'h01,
    SWHW_MSG_TYPE_VENUE_BOUND_WRAPPED  = 8'h02
  } swhw_msg_type_enum_t;

  localparam int LANE_CONTROLLER = 0;
  localparam int LANE_OUTBOUND   = 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through FIFO: a write is visible on rd_dat the cycle after it lands.
// full/empty come straight from registers, so a pop never frees space for a same-cycle write.
module axis_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_dat,
  output logic              full,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_dat,
  input  logic              rd_rdy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              push, pop;

  always_comb begin
    push     = wr_vld && !full_q;
    pop      = rd_rdy && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    full_d   = (cnt_d == CW'(DEPTH));
    empty_d  = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign full   = full_q;
  assign rd_vld = !empty_q;
  assign rd_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/axis_lane_replicator.sv
// Routes each packet by its first-beat type byte to a lane mask and copies it into per-lane FIFOs.
// One cycle accept-to-output; input stalls only while a lane in the packet's mask has a full FIFO.
module axis_lane_replicator
  import swhw_msg_pkg::*;
#(
  parameter int                      DATA_W       = 32,
  parameter int                      NUM_TX_LANES = 2,
  parameter int                      FIFO_DEPTH   = 16,
  parameter logic [NUM_TX_LANES-1:0] REG_MASK     = '1,
  parameter logic [NUM_TX_LANES-1:0] VBW_MASK     = '1
) (
  input  logic                    tx_clk,
  input  logic                    tx_rst,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_W-1:0]       s_axis_tdata,
  input  logic [DATA_W/8-1:0]     s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic [NUM_TX_LANES-1:0] lane_enable,
  output logic                    m_axis_tvalid [NUM_TX_LANES-1:0],
  output logic [DATA_W-1:0]       m_axis_tdata  [NUM_TX_LANES-1:0],
  output logic [DATA_W/8-1:0]     m_axis_tkeep  [NUM_TX_LANES-1:0],
  output logic                    m_axis_tlast  [NUM_TX_LANES-1:0],
  input  logic                    m_axis_tready [NUM_TX_LANES-1:0],
  output logic [31:0]             pkt_count,
  output logic [15:0]             drop_count
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PW     = DATA_W + KEEP_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_e;

  state_e                  state_q, state_d;
  logic [NUM_TX_LANES-1:0] mask_q, mask_d;
  logic [31:0]             pkt_cnt_q, pkt_cnt_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic [NUM_TX_LANES-1:0] type_mask, cur_mask, lane_full, lane_wr;
  logic                    accept;
  logic [PW-1:0]           wr_dat;
  logic [PW-1:0]           lane_rd_dat [NUM_TX_LANES];

  always_comb begin
    type_mask = '0;
    case (s_axis_tdata[7:0])
      8'(SWHW_MSG_TYPE_SESSION_REGISTRATION): type_mask = REG_MASK;
      8'(SWHW_MSG_TYPE_VENUE_BOUND_WRAPPED):  type_mask = VBW_MASK;
      default:                                type_mask = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;

    // In IDLE the mask comes from the beat on the bus; afterwards it is frozen for the packet.
    cur_mask = (state_q == ST_IDLE) ? (type_mask & lane_enable) : mask_q;

    if (tx_rst)                  s_axis_tready = 1'b0;
    else if (state_q == ST_DROP) s_axis_tready = 1'b1;
    else                         s_axis_tready = ~|(cur_mask & lane_full);

    accept  = s_axis_tvalid && s_axis_tready;
    lane_wr = (accept && state_q != ST_DROP) ? cur_mask : '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (|cur_mask) begin
            mask_d = cur_mask;
            if (s_axis_tlast) pkt_cnt_d = pkt_cnt_q + 32'd1;
            else              state_d   = ST_FWD;
          end else begin
            if (s_axis_tlast) drop_cnt_d = sat_inc16(drop_cnt_q);
            else              state_d    = ST_DROP;
          end
        end
      end
      ST_FWD: begin
        if (accept && s_axis_tlast) begin
          state_d   = ST_IDLE;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
      end
      ST_DROP: begin
        if (accept && s_axis_tlast) begin
          state_d    = ST_IDLE;
          drop_cnt_d = sat_inc16(drop_cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign wr_dat     = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;

  for (genvar i = 0; i < NUM_TX_LANES; i++) begin : g_lane
    axis_sync_fifo #(
      .DATA_W (PW),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk    (tx_clk),
      .rst    (tx_rst),
      .wr_vld (lane_wr[i]),
      .wr_dat (wr_dat),
      .full   (lane_full[i]),
      .rd_vld (m_axis_tvalid[i]),
      .rd_dat (lane_rd_dat[i]),
      .rd_rdy (m_axis_tready[i])
    );
    assign {m_axis_tlast[i], m_axis_tkeep[i], m_axis_tdata[i]} = lane_rd_dat[i];
  end

endmodule
